// File: rtl/alu_arbiter.sv
// Shares one 16-bit ALU between two valid/ready requesters, returning each result to its owner.
// Build option: define ALU_ARB_FIXED_PRI_EN to give requester 0 fixed priority instead of round-robin.
module alu_arbiter #(
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_lastGrant;
  logic              r_owner;
  logic [3:0]        r_count;
  logic [SEL_W-1:0]  r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp0Data;
  logic [DATA_W-1:0] r_rsp1Data;
  logic              w_grant;
  logic              w_accept;

  // Contention goes to the requester that did not win last time, unless fixed priority is built in.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      w_grant = 1'b0;
`else
      w_grant = ~r_lastGrant;
`endif
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept  = (r_state == IDLE) && rst_n && (req0_valid || req1_valid);
  assign rsp0_data = r_rsp0Data;
  assign rsp1_data = r_rsp1Data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    alu_sel     = '0;
    alu_a       = '0;
    alu_b       = '0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = rst_n && req0_valid && !w_grant;
        req1_ready = rst_n && req1_valid && w_grant;
        if (w_accept) w_nextState = EXEC;
      end
      EXEC: begin
        alu_sel = r_op;
        alu_a   = r_a;
        alu_b   = r_b;
        if (r_count == 4'd0) w_nextState = RESP;
      end
      RESP: begin
        rsp0_valid = !r_owner;
        rsp1_valid = r_owner;
        if (r_owner ? rsp1_ready : rsp0_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The result register is written only on the final EXEC cycle, so it holds after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_count     <= 4'd0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp0Data  <= '0;
      r_rsp1Data  <= '0;
    end else if (w_accept) begin
      r_op        <= w_grant ? req1_op : req0_op;
      r_a         <= w_grant ? req1_a : req0_a;
      r_b         <= w_grant ? req1_b : req0_b;
      r_owner     <= w_grant;
      r_lastGrant <= w_grant;
      r_count     <= CNT_LOAD;
    end else if (r_state == EXEC) begin
      if (r_count == 4'd0) begin
        if (r_owner) r_rsp1Data <= alu_out;
        else         r_rsp0Data <= alu_out;
      end else begin
        r_count <= r_count - 4'd1;
      end
    end
  end

endmodule
